wta_k_sync: RTL and testbench

//   Clocked, parametrised k-winner-take-all for temporally coded spike columns.

---
 rtl/wta_pkg.sv | 42 ++++
 rtl/wta_pulse_gen.sv | 42 ++++
 rtl/wta_k_sync.sv | 162 ++++++++++++++++
 tb/tb_wta_k_sync.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wta_pkg.sv
`default_nettype none
// wta_pkg: state encoding and bit-vector helpers shared by the k-winner-take-all block.
// Rev 1.0
package wta_pkg;

    localparam int WTA_MAX_W = 64;
    localparam int WTA_CNT_W = $clog2(WTA_MAX_W + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        SATURATED = 2'd2
    } wta_state_t;

    function automatic logic [WTA_MAX_W-1:0] lowest_n(
        input logic [WTA_MAX_W-1:0] vec,
        input logic [31:0]          n
    );
        logic [WTA_MAX_W-1:0] res;
        logic [31:0]          taken;
        res   = '0;
        taken = '0;
        for (int i = 0; i < WTA_MAX_W; i++) begin
            if (vec[i] && (taken < n)) begin
                res[i] = 1'b1;
                taken  = taken + 32'd1;
            end
        end
        return res;
    endfunction

    function automatic logic [WTA_CNT_W-1:0] popcount(input logic [WTA_MAX_W-1:0] vec);
        logic [WTA_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WTA_MAX_W; i++) begin
            cnt = cnt + WTA_CNT_W'(vec[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wta_pulse_gen.sv
`default_nettype none
// wta_pulse_gen: per-channel stretcher, output high for PULSE_WIDTH cycles after fire.
// Rev 1.0
module wta_pulse_gen #(
    parameter int PULSE_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    input  logic clr,
    output logic pulse
);

    localparam int CW = $clog2(PULSE_WIDTH + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over fire so a gamma wrap truncates any pulse, including one starting now.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = CW'(PULSE_WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse = (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/wta_k_sync.sv
`default_nettype none
// wta_k_sync: clocked k-winner-take-all over temporally coded spike lines per gamma cycle.
// Rev 1.0
module wta_k_sync
    import wta_pkg::*;
#(
    parameter int NUM_INPUTS        = 16,
    parameter int K                 = 1,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int LEVEL_MODE        = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [GAMMA_CYCLE_WIDTH-1:0] gamma_len,
    input  logic [NUM_INPUTS-1:0]        input_spikes,
    output logic [NUM_INPUTS-1:0]        output_spikes,
    output logic [NUM_INPUTS-1:0]        winner_mask,
    output logic [$clog2(K+1)-1:0]       win_count,
    output logic [GAMMA_CYCLE_WIDTH-1:0] first_time,
    output logic                         gamma_start
);

    localparam int GW  = GAMMA_CYCLE_WIDTH;
    localparam int WCW = $clog2(K + 1);

    wta_state_t            state_q, state_d;
    logic [GW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         len_q, len_d;
    logic [NUM_INPUTS-1:0] prev_q;
    logic [NUM_INPUTS-1:0] mask_q, mask_d;
    logic [WCW-1:0]        count_q, count_d;
    logic [GW-1:0]         first_q, first_d;
    logic                  start_q, start_d;

    logic [NUM_INPUTS-1:0] w_cand;
    logic [NUM_INPUTS-1:0] w_elig;
    logic [NUM_INPUTS-1:0] w_admit;
    logic [NUM_INPUTS-1:0] w_fire;
    logic [31:0]           w_slots;
    logic                  w_wrap;
    logic                  w_clr;

    assign w_cand  = (LEVEL_MODE != 0) ? input_spikes : (input_spikes & ~prev_q);
    assign w_elig  = w_cand & ~mask_q;
    assign w_slots = 32'(K) - 32'(count_q);
    assign w_admit = (state_q == ARMED) ? NUM_INPUTS'(lowest_n(WTA_MAX_W'(w_elig), w_slots)) : '0;
    assign w_wrap  = (state_q != IDLE) && (cnt_q == (len_q - GW'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mask_d  = mask_q;
        count_d = count_q;
        first_d = first_q;
        start_d = 1'b0;
        w_fire  = '0;
        w_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                mask_d  = '0;
                count_d = '0;
                first_d = '0;
                w_clr   = 1'b1;
                if (enable && (gamma_len != '0)) begin
                    state_d = ARMED;
                    len_d   = gamma_len;
                    start_d = 1'b1;
                end
            end
            ARMED, SATURATED: begin
                cnt_d = cnt_q + GW'(1);
                if (w_admit != '0) begin
                    w_fire  = w_admit;
                    mask_d  = mask_q | w_admit;
                    count_d = count_q + WCW'(popcount(WTA_MAX_W'(w_admit)));
                    if (count_q == '0) begin
                        first_d = cnt_q;
                    end
                    if (count_d == WCW'(K)) begin
                        state_d = SATURATED;
                    end
                end
                // A win in the wrap cycle belongs to the ending cycle and is wiped with it.
                if (w_wrap) begin
                    cnt_d   = '0;
                    mask_d  = '0;
                    count_d = '0;
                    first_d = '0;
                    w_fire  = '0;
                    w_clr   = 1'b1;
                    len_d   = gamma_len;
                    if (gamma_len != '0) begin
                        state_d = ARMED;
                        start_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            mask_d  = '0;
            count_d = '0;
            first_d = '0;
            start_d = 1'b0;
            w_fire  = '0;
            w_clr   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            first_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            prev_q  <= input_spikes;
            mask_q  <= mask_d;
            count_q <= count_d;
            first_q <= first_d;
            start_q <= start_d;
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pulse
        wta_pulse_gen #(
            .PULSE_WIDTH(PULSE_WIDTH)
        ) u_pulse (
            .clk   (clk),
            .rst   (rst),
            .fire  (w_fire[g]),
            .clr   (w_clr),
            .pulse (output_spikes[g])
        );
    end

    assign winner_mask = mask_q;
    assign win_count   = count_q;
    assign first_time  = first_q;
    assign gamma_start = start_q;

endmodule
`default_nettype wire

// File: tb/tb_wta_k_sync.sv
`default_nettype none
// tb_wta_k_sync: directed scoreboard bench driving three k-WTA configurations from one stimulus bus.
// Rev 1.0
module tb_wta_k_sync;

    localparam int F_OSP = 0;
    localparam int F_WM  = 1;
    localparam int F_WC  = 2;
    localparam int F_FT  = 3;
    localparam int F_GS  = 4;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        enable       = 1'b0;
    logic [15:0] gamma_len    = '0;
    logic [15:0] input_spikes = '0;

    logic [15:0] osp0, wm0, ft0, osp1, wm1, ft1, osp2, wm2, ft2;
    logic        wc0, wc2, gs0, gs1, gs2;
    logic [1:0]  wc1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // d0: K=1 edge mode, d1: K=2 edge mode, d2: K=1 level mode.
    wta_k_sync #(.NUM_INPUTS(16), .K(1), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .LEVEL_MODE(0)) u_d0 (
        .clk(clk), .rst(rst), .enable(enable), .gamma_len(gamma_len), .input_spikes(input_spikes),
        .output_spikes(osp0), .winner_mask(wm0), .win_count(wc0), .first_time(ft0), .gamma_start(gs0)
    );
    wta_k_sync #(.NUM_INPUTS(16), .K(2), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .LEVEL_MODE(0)) u_d1 (
        .clk(clk), .rst(rst), .enable(enable), .gamma_len(gamma_len), .input_spikes(input_spikes),
        .output_spikes(osp1), .winner_mask(wm1), .win_count(wc1), .first_time(ft1), .gamma_start(gs1)
    );
    wta_k_sync #(.NUM_INPUTS(16), .K(1), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .LEVEL_MODE(1)) u_d2 (
        .clk(clk), .rst(rst), .enable(enable), .gamma_len(gamma_len), .input_spikes(input_spikes),
        .output_spikes(osp2), .winner_mask(wm2), .win_count(wc2), .first_time(ft2), .gamma_start(gs2)
    );

    typedef struct {
        int          c;
        int          sel;
        logic [31:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:  return 32'(osp0);
            1:  return 32'(wm0);
            2:  return 32'(wc0);
            3:  return 32'(ft0);
            4:  return 32'(gs0);
            8:  return 32'(osp1);
            9:  return 32'(wm1);
            10: return 32'(wc1);
            11: return 32'(ft1);
            12: return 32'(gs1);
            16: return 32'(osp2);
            17: return 32'(wm2);
            18: return 32'(wc2);
            19: return 32'(ft2);
            20: return 32'(gs2);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic void push_exp(input int c, input int d, input int f, input logic [31:0] v, input string nm);
        exp_t e;
        e.c   = c;
        e.sel = d * 8 + f;
        e.v   = v;
        e.nm  = $sformatf("d%0d.%s", d, nm);
        sb.push_back(e);
    endfunction

    // Monitor: compares every scoreboard entry whose cycle has arrived.
    initial begin : monitor
        int          i;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].c == cyc) begin
                    act = probe(sb[i].sel);
                    n_vec++;
                    if (act !== sb[i].v) begin
                        n_err++;
                        $display("FAIL %s cyc %0d: got 0x%0h, expected 0x%0h", sb[i].nm, cyc, act, sb[i].v);
                    end
                    sb.delete(i);
                end else if ((sb[i].c < cyc) || done) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL %s cyc %0d: not sampled (now %0d), expected 0x%0h", sb[i].nm, sb[i].c, cyc, sb[i].v);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic restart(input logic [15:0] len);
        rst          = 1'b0;
        enable       = 1'b0;
        input_spikes = '0;
        gamma_len    = len;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin : stim
        int s;
        int r;
        int z;

        // Reset state
        step();
        push_exp(cyc, 0, F_OSP, 0, "osp");
        push_exp(cyc, 0, F_WM,  0, "wm");
        push_exp(cyc, 0, F_WC,  0, "wc");
        push_exp(cyc, 0, F_FT,  0, "ft");
        push_exp(cyc, 0, F_GS,  0, "gs");
        push_exp(cyc, 1, F_WC,  0, "wc");
        step();

        // Single winner: ch5 at cnt 3, ch2 at cnt 6, gamma_len 20
        restart(16'd20);
        enable = 1'b1;
        s = cyc + 1;
        push_exp(s,      0, F_GS,  1, "gs");
        push_exp(s + 1,  0, F_GS,  0, "gs");
        push_exp(s + 3,  0, F_OSP, 0, "osp");
        push_exp(s + 4,  0, F_OSP, 32'h0020, "osp");
        push_exp(s + 4,  0, F_WC,  1, "wc");
        push_exp(s + 5,  0, F_FT,  3, "ft");
        push_exp(s + 7,  0, F_OSP, 32'h0020, "osp");
        push_exp(s + 8,  0, F_WM,  32'h0020, "wm");
        push_exp(s + 11, 0, F_OSP, 32'h0020, "osp");
        push_exp(s + 12, 0, F_OSP, 0, "osp");
        push_exp(s + 12, 0, F_FT,  3, "ft");
        push_exp(s + 19, 0, F_GS,  0, "gs");
        push_exp(s + 20, 0, F_GS,  1, "gs");
        push_exp(s + 20, 0, F_WM,  0, "wm");
        push_exp(s + 20, 0, F_WC,  0, "wc");
        push_exp(s + 20, 0, F_FT,  0, "ft");
        push_exp(s + 7,  1, F_WM,  32'h0024, "wm");
        push_exp(s + 7,  1, F_WC,  2, "wc");
        push_exp(s + 7,  1, F_FT,  3, "ft");
        goto_cyc(s + 3);
        input_spikes = 16'h0020;
        step();
        input_spikes = '0;
        goto_cyc(s + 6);
        input_spikes = 16'h0004;
        step();
        input_spikes = '0;
        goto_cyc(s + 22);

        // Tie-break: ch9, ch4, ch1 together at cnt 2
        restart(16'd20);
        enable = 1'b1;
        s = cyc + 1;
        push_exp(s + 2,  1, F_OSP, 0, "osp");
        push_exp(s + 3,  1, F_OSP, 32'h0012, "osp");
        push_exp(s + 3,  1, F_WM,  32'h0012, "wm");
        push_exp(s + 3,  1, F_WC,  2, "wc");
        push_exp(s + 3,  1, F_FT,  2, "ft");
        push_exp(s + 10, 1, F_WM,  32'h0012, "wm");
        push_exp(s + 3,  0, F_WM,  32'h0002, "wm");
        goto_cyc(s + 2);
        input_spikes = 16'h0212;
        step();
        input_spikes = '0;
        goto_cyc(s + 12);

        // Edge vs level: ch0 held high cnt 0..30, gamma_len 10
        restart(16'd10);
        enable = 1'b1;
        s = cyc + 1;
        push_exp(s + 1,  0, F_OSP, 1, "osp");
        push_exp(s + 8,  0, F_OSP, 1, "osp");
        push_exp(s + 9,  0, F_OSP, 0, "osp");
        push_exp(s + 5,  0, F_WM,  1, "wm");
        push_exp(s + 10, 0, F_GS,  1, "gs");
        push_exp(s + 11, 0, F_WM,  0, "wm");
        push_exp(s + 21, 0, F_WM,  0, "wm");
        push_exp(s + 21, 0, F_WC,  0, "wc");
        push_exp(s + 1,  2, F_WM,  1, "wm");
        push_exp(s + 10, 2, F_WM,  0, "wm");
        push_exp(s + 11, 2, F_WM,  1, "wm");
        push_exp(s + 11, 2, F_OSP, 1, "osp");
        push_exp(s + 11, 2, F_WC,  1, "wc");
        push_exp(s + 20, 2, F_GS,  1, "gs");
        push_exp(s + 21, 2, F_WM,  1, "wm");
        push_exp(s + 31, 2, F_WM,  1, "wm");
        goto_cyc(s);
        input_spikes = 16'h0001;
        goto_cyc(s + 31);
        input_spikes = '0;
        goto_cyc(s + 33);

        // Truncation: gamma_len 5, spike ch3 at cnt 1
        restart(16'd5);
        enable = 1'b1;
        s = cyc + 1;
        push_exp(s + 1,  0, F_OSP, 0, "osp");
        push_exp(s + 2,  0, F_OSP, 32'h0008, "osp");
        push_exp(s + 4,  0, F_OSP, 32'h0008, "osp");
        push_exp(s + 4,  0, F_GS,  0, "gs");
        push_exp(s + 5,  0, F_OSP, 0, "osp");
        push_exp(s + 5,  0, F_GS,  1, "gs");
        push_exp(s + 10, 0, F_GS,  1, "gs");
        goto_cyc(s + 1);
        input_spikes = 16'h0008;
        step();
        input_spikes = '0;
        goto_cyc(s + 12);

        // Reset mid-pulse, then release with enable high
        restart(16'd20);
        enable = 1'b1;
        s = cyc + 1;
        r = s + 6;
        push_exp(s + 3,  0, F_OSP, 32'h0080, "osp");
        push_exp(s + 4,  0, F_OSP, 32'h0080, "osp");
        push_exp(s + 5,  0, F_OSP, 0, "osp");
        push_exp(s + 5,  0, F_WM,  0, "wm");
        push_exp(s + 5,  0, F_WC,  0, "wc");
        push_exp(s + 5,  0, F_FT,  0, "ft");
        push_exp(s + 5,  1, F_OSP, 0, "osp");
        push_exp(r,      0, F_GS,  0, "gs");
        push_exp(r + 1,  0, F_GS,  1, "gs");
        push_exp(r + 2,  0, F_GS,  0, "gs");
        push_exp(r + 4,  0, F_FT,  2, "ft");
        push_exp(r + 4,  0, F_OSP, 32'h0002, "osp");
        goto_cyc(s + 2);
        input_spikes = 16'h0080;
        step();
        input_spikes = '0;
        goto_cyc(s + 5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        goto_cyc(r + 3);
        input_spikes = 16'h0002;
        step();
        input_spikes = '0;
        goto_cyc(r + 6);

        // Enable drop at cnt 7, then zero gamma_len with enable high
        restart(16'd20);
        enable = 1'b1;
        s = cyc + 1;
        z = s + 10;
        push_exp(s + 4,  0, F_OSP, 32'h0040, "osp");
        push_exp(s + 7,  0, F_OSP, 32'h0040, "osp");
        push_exp(s + 7,  0, F_WM,  32'h0040, "wm");
        push_exp(s + 7,  0, F_WC,  1, "wc");
        push_exp(s + 7,  0, F_FT,  3, "ft");
        push_exp(s + 8,  0, F_OSP, 0, "osp");
        push_exp(s + 8,  0, F_WM,  0, "wm");
        push_exp(s + 8,  0, F_WC,  0, "wc");
        push_exp(s + 8,  0, F_FT,  0, "ft");
        push_exp(z + 1,  0, F_GS,  0, "gs");
        push_exp(z + 2,  0, F_GS,  0, "gs");
        push_exp(z + 3,  0, F_OSP, 0, "osp");
        push_exp(z + 3,  0, F_WM,  0, "wm");
        goto_cyc(s + 3);
        input_spikes = 16'h0040;
        step();
        input_spikes = '0;
        goto_cyc(s + 7);
        enable = 1'b0;
        goto_cyc(z);
        gamma_len = 16'd0;
        enable    = 1'b1;
        step();
        input_spikes = 16'h0040;
        step();
        input_spikes = '0;
        goto_cyc(z + 5);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
